// File: rtl/spi_slave_word.sv
// Word-level SPI slave: oversampled pins, all CPOL/CPHA modes,
// tx holding buffer with valid/ready, rx valid pulse, optional loopback.
module spi_slave_word #(
  parameter int DATA_W = 8,
  parameter int CPOL = 0,
  parameter int CPHA = 0,
  parameter int MSB_FIRST = 1,
  parameter logic [DATA_W-1:0] TX_IDLE = '1,
  parameter int LOOPBACK = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              tx_underrun,
  output logic              cs_abort
);

  localparam int CW = $clog2(DATA_W);
  localparam logic L_POL = (CPOL != 0);
  localparam logic L_PHA = (CPHA != 0);
  localparam logic L_MSB = (MSB_FIRST != 0);
  localparam logic L_LB = (LOOPBACK != 0);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACT = 1'b1;

  logic [0:0]        r_state;
  logic [1:0]        r_cs_s;
  logic [1:0]        r_sclk_s;
  logic [1:0]        r_mosi_s;
  logic              r_cs_q;
  logic              r_sclk_q;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_tx_sr;
  logic [DATA_W-1:0] r_rx_sr;
  logic [DATA_W-1:0] r_buf;
  logic [DATA_W-1:0] r_lb;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_full;
  logic              r_pend;
  logic              r_first;
  logic              r_rx_valid;
  logic              r_under;
  logic              r_abort;

  logic              w_cs_fall;
  logic              w_cs_rise;
  logic              w_rise;
  logic              w_fall;
  logic              w_lead;
  logic              w_trail;
  logic              w_samp;
  logic              w_shift;
  logic              w_act;
  logic              w_start;
  logic              w_samp_a;
  logic              w_shift_a;
  logic              w_last;
  logic              w_load;
  logic              w_consume;
  logic              w_under;
  logic              w_push;
  logic              w_mosi;
  logic [DATA_W-1:0] w_rx_word;
  logic [DATA_W-1:0] w_lb_src;
  logic [DATA_W-1:0] w_src;
  logic [DATA_W-1:0] w_tx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_s   <= 2'b11;
      r_cs_q   <= 1'b1;
      r_sclk_s <= {2{L_POL}};
      r_sclk_q <= L_POL;
      r_mosi_s <= 2'b00;
    end else begin
      r_cs_s   <= {r_cs_s[0], cs};
      r_cs_q   <= r_cs_s[1];
      r_sclk_s <= {r_sclk_s[0], sclk};
      r_sclk_q <= r_sclk_s[1];
      r_mosi_s <= {r_mosi_s[0], mosi};
    end
  end

  assign w_cs_fall = r_cs_q & ~r_cs_s[1];
  assign w_cs_rise = ~r_cs_q & r_cs_s[1];
  assign w_rise    = ~r_sclk_q & r_sclk_s[1];
  assign w_fall    = r_sclk_q & ~r_sclk_s[1];
  assign w_lead    = L_POL ? w_fall : w_rise;
  assign w_trail   = L_POL ? w_rise : w_fall;
  assign w_samp    = L_PHA ? w_trail : w_lead;
  assign w_shift   = L_PHA ? w_lead : w_trail;
  assign w_mosi    = r_mosi_s[1];

  assign w_act     = (r_state == S_ACT) & ~w_cs_rise;
  assign w_start   = (r_state == S_IDLE) & w_cs_fall;
  assign w_samp_a  = w_act & w_samp;
  assign w_shift_a = w_act & w_shift;
  assign w_last    = w_samp_a & (r_cnt == CW'(DATA_W - 1));

  // CPHA=0 reloads on the shift edge after the last sample, CPHA=1 at once.
  assign w_load = w_start |
    (L_PHA ? w_last : (w_shift_a & r_pend));

  assign w_rx_word = L_MSB ?
    {r_rx_sr[DATA_W-2:0], w_mosi} :
    {w_mosi, r_rx_sr[DATA_W-1:1]};
  assign w_tx_shift = L_MSB ?
    {r_tx_sr[DATA_W-2:0], 1'b0} :
    {1'b0, r_tx_sr[DATA_W-1:1]};

  assign w_lb_src  = w_last ? w_rx_word : r_lb;
  assign w_src     = L_LB ? w_lb_src :
                     (r_full ? r_buf : TX_IDLE);
  assign w_consume = w_load & ~L_LB & r_full;
  assign w_under   = w_load & ~L_LB & ~r_full;
  assign w_push    = tx_valid & tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf  <= '0;
      r_full <= 1'b0;
    end else if (w_push) begin
      r_buf  <= tx_data;
      r_full <= 1'b1;
    end else if (w_consume) begin
      r_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_lb       <= '0;
      r_rx_data  <= '0;
      r_pend     <= 1'b0;
      r_first    <= 1'b0;
      r_rx_valid <= 1'b0;
      r_under    <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_under    <= w_under;
      r_abort    <= 1'b0;
      if (w_start) begin
        r_state <= S_ACT;
      end else if ((r_state == S_ACT) && w_cs_rise) begin
        r_state <= S_IDLE;
        r_abort <= (r_cnt != '0);
      end
      if (!w_act) begin
        r_cnt  <= '0;
        r_pend <= 1'b0;
      end else if (w_samp) begin
        r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
        r_rx_sr <= w_rx_word;
      end
      if (w_last) begin
        r_rx_data  <= w_rx_word;
        r_rx_valid <= 1'b1;
        r_lb       <= w_rx_word;
        r_pend     <= ~L_PHA;
      end
      // First leading edge of a CPHA=1 word keeps the preloaded bit.
      if (w_load) begin
        r_tx_sr <= w_src;
        r_first <= L_PHA;
        r_pend  <= 1'b0;
      end else if (w_shift_a) begin
        r_first <= 1'b0;
        if (!r_first) r_tx_sr <= w_tx_shift;
      end
    end
  end

  assign miso = (r_state == S_ACT) ?
    (L_MSB ? r_tx_sr[DATA_W-1] : r_tx_sr[0]) : 1'bz;
  assign tx_ready    = ~L_LB & ~r_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign busy        = (r_state == S_ACT);
  assign tx_underrun = r_under;
  assign cs_abort    = r_abort;

endmodule

// File: tb/tb_spi_slave_word.sv
// Bench for spi_slave_word: four configurations on a shared sclk/mosi,
// rx words scoreboarded, master reads checked against a queue.
module tb_spi_slave_word;

  localparam int H = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic cs0 = 1'b1, cs1 = 1'b1, cs3 = 1'b1, csl = 1'b1;
  logic miso0, miso1, miso3, misol;
  logic tv0 = 1'b0, tv1 = 1'b0, tv3 = 1'b0, tvl = 1'b0;
  logic [7:0] td0 = '0, td1 = '0, td3 = '0;
  logic [15:0] tdl = '0;
  logic rdy0, rdy1, rdy3, rdyl;
  logic [7:0] rxd0, rxd1, rxd3;
  logic [15:0] rxdl;
  logic rxv0, rxv1, rxv3, rxvl;
  logic bsy0, bsy1, bsy3, bsyl;
  logic und0, und1, und3, undl;
  logic abt0, abt1, abt3, abtl;

  int n_tests = 0;
  int n_fail = 0;
  int n_rxv[4] = '{default: 0};
  int n_und[4] = '{default: 0};
  int n_abt[4] = '{default: 0};
  int n_lbrdy = 0;
  int q_dev[$];
  logic [31:0] q_rx[$];
  logic [31:0] q_mi[$];

  always #5 clk = ~clk;

  spi_slave_word #(.DATA_W(8)) u_m0 (
    .clk(clk), .rst_n(rst_n), .cs(cs0), .sclk(sclk),
    .mosi(mosi), .miso(miso0), .tx_data(td0),
    .tx_valid(tv0), .tx_ready(rdy0), .rx_data(rxd0),
    .rx_valid(rxv0), .busy(bsy0), .tx_underrun(und0),
    .cs_abort(abt0));

  spi_slave_word #(.CPHA(1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .cs(cs1), .sclk(sclk),
    .mosi(mosi), .miso(miso1), .tx_data(td1),
    .tx_valid(tv1), .tx_ready(rdy1), .rx_data(rxd1),
    .rx_valid(rxv1), .busy(bsy1), .tx_underrun(und1),
    .cs_abort(abt1));

  spi_slave_word #(.CPOL(1), .CPHA(1)) u_m3 (
    .clk(clk), .rst_n(rst_n), .cs(cs3), .sclk(sclk),
    .mosi(mosi), .miso(miso3), .tx_data(td3),
    .tx_valid(tv3), .tx_ready(rdy3), .rx_data(rxd3),
    .rx_valid(rxv3), .busy(bsy3), .tx_underrun(und3),
    .cs_abort(abt3));

  spi_slave_word #(
    .DATA_W(16), .MSB_FIRST(0), .LOOPBACK(1)
  ) u_lb (
    .clk(clk), .rst_n(rst_n), .cs(csl), .sclk(sclk),
    .mosi(mosi), .miso(misol), .tx_data(tdl),
    .tx_valid(tvl), .tx_ready(rdyl), .rx_data(rxdl),
    .rx_valid(rxvl), .busy(bsyl), .tx_underrun(undl),
    .cs_abort(abtl));

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rx_check(input int dev, input logic [31:0] d);
    int ed;
    logic [31:0] ev;
    if (q_rx.size() == 0) begin
      check($sformatf("rx_unexpected_dev%0d", dev), q_rx.size(), 1);
    end else begin
      ed = q_dev.pop_front();
      ev = q_rx.pop_front();
      check($sformatf("rx_dev%0d", dev), dev, ed);
      check($sformatf("rx_data_dev%0d", dev), d, ev);
    end
  endtask

  always @(negedge clk) begin
    if (rxv0) begin n_rxv[0]++; rx_check(0, {24'h0, rxd0}); end
    if (rxv1) begin n_rxv[1]++; rx_check(1, {24'h0, rxd1}); end
    if (rxvl) begin n_rxv[2]++; rx_check(2, {16'h0, rxdl}); end
    if (rxv3) begin n_rxv[3]++; rx_check(3, {24'h0, rxd3}); end
    if (und0) n_und[0]++;
    if (und1) n_und[1]++;
    if (undl) n_und[2]++;
    if (und3) n_und[3]++;
    if (abt0) n_abt[0]++;
    if (abt1) n_abt[1]++;
    if (abtl) n_abt[2]++;
    if (abt3) n_abt[3]++;
    if (rdyl) n_lbrdy++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic get_miso(input int dev);
    case (dev)
      0: return miso0;
      1: return miso1;
      2: return misol;
      default: return miso3;
    endcase
  endfunction

  task automatic set_cs(input int dev, input logic v);
    @(negedge clk);
    case (dev)
      0: cs0 = v;
      1: cs1 = v;
      2: csl = v;
      default: cs3 = v;
    endcase
  endtask

  task automatic load(input int dev, input logic [7:0] v);
    @(negedge clk);
    if (dev == 0) begin tv0 = 1'b1; td0 = v; end
    else begin tv3 = 1'b1; td3 = v; end
    @(negedge clk);
    tv0 = 1'b0;
    tv3 = 1'b0;
    check($sformatf("load%0d_rdy_low", dev),
          (dev == 0) ? rdy0 : rdy3, 0);
  endtask

  // Master clocks nclk bits of a word in the device's mode.
  task automatic xfer(input int dev, input logic [31:0] w,
                      input int nclk, output logic [31:0] rd);
    bit cpol = (dev == 3);
    bit cpha = (dev == 1) || (dev == 3);
    bit msb = (dev != 2);
    int nb = (dev == 2) ? 16 : 8;
    rd = '0;
    for (int i = 0; i < nclk; i++) begin
      int b = msb ? nb - 1 - i : i;
      if (!cpha) begin
        mosi = w[b];
        wait_clk(H);
        rd[b] = get_miso(dev);
        sclk = ~cpol;
        wait_clk(H);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = w[b];
        wait_clk(H);
        rd[b] = get_miso(dev);
        sclk = cpol;
        wait_clk(H);
      end
    end
  endtask

  task automatic word(input int dev, input logic [31:0] w,
                      input string tag);
    logic [31:0] rd;
    int nb = (dev == 2) ? 16 : 8;
    q_dev.push_back(dev);
    q_rx.push_back(w);
    xfer(dev, w, nb, rd);
    if (q_mi.size() == 0) check({tag, "_noexp"}, q_mi.size(), 1);
    else check(tag, rd, q_mi.pop_front());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int u, r0, a0;
    wait_clk(3);
    check("rst_rdy0", rdy0, 1);
    check("rst_busy0", bsy0, 0);
    check("rst_rxd0", rxd0, 0);
    check("rst_miso0_z", miso0 === 1'bz, 1);
    check("rst_rdyl", rdyl, 0);
    rst_n = 1'b1;
    wait_clk(4);

    q_mi.push_back(32'hA5);
    load(0, 8'hA5);
    set_cs(0, 1'b0);
    wait_clk(8);
    check("m0_busy", bsy0, 1);
    check("m0_rdy_back", rdy0, 1);
    word(0, 32'h3C, "m0_rd");
    wait_clk(8);
    set_cs(0, 1'b1);
    wait_clk(8);
    check("m0_rxv_cnt", n_rxv[0], 1);
    check("m0_busy_off", bsy0, 0);

    sclk = 1'b1;
    wait_clk(8);
    q_mi.push_back(32'h12);
    q_mi.push_back(32'h34);
    load(3, 8'h12);
    u = n_und[3];
    set_cs(3, 1'b0);
    wait_clk(8);
    check("m3_rdy_free", rdy3, 1);
    load(3, 8'h34);
    word(3, 32'hF0, "m3_rd0");
    check("m3_no_under", n_und[3] - u, 0);
    word(3, 32'h0F, "m3_rd1");
    wait_clk(8);
    set_cs(3, 1'b1);
    wait_clk(8);
    sclk = 1'b0;
    wait_clk(8);
    check("m3_rxv_cnt", n_rxv[3], 2);

    u = n_und[1];
    q_mi.push_back(32'hFF);
    set_cs(1, 1'b0);
    wait_clk(8);
    check("m1_under_pulse", n_und[1] - u, 1);
    word(1, 32'h77, "m1_rd_idle");
    wait_clk(8);
    set_cs(1, 1'b1);
    wait_clk(8);

    r0 = n_rxv[0];
    a0 = n_abt[0];
    set_cs(0, 1'b0);
    wait_clk(8);
    xfer(0, 32'hB7, 5, rd);
    wait_clk(8);
    set_cs(0, 1'b1);
    wait_clk(3);
    check("ab_miso_z", miso0 === 1'bz, 1);
    wait_clk(5);
    check("ab_pulse", n_abt[0] - a0, 1);
    check("ab_no_rxv", n_rxv[0] - r0, 0);
    q_mi.push_back(32'h5A);
    load(0, 8'h5A);
    set_cs(0, 1'b0);
    wait_clk(8);
    word(0, 32'hC3, "ab_next_rd");
    wait_clk(8);
    set_cs(0, 1'b1);
    wait_clk(8);

    q_mi.push_back(32'h0000);
    q_mi.push_back(32'h1111);
    set_cs(2, 1'b0);
    wait_clk(8);
    word(2, 32'h1111, "lb_rd0");
    word(2, 32'h2222, "lb_rd1");
    wait_clk(8);
    set_cs(2, 1'b1);
    wait_clk(8);
    check("lb_rdy_never", n_lbrdy, 0);
    check("lb_rxv_cnt", n_rxv[2], 2);

    load(0, 8'h96);
    set_cs(0, 1'b0);
    wait_clk(8);
    xfer(0, 32'hFF, 3, rd);
    @(negedge clk);
    rst_n = 1'b0;
    cs0 = 1'b1;
    #1;
    check("mr_miso_z", miso0 === 1'bz, 1);
    check("mr_busy", bsy0, 0);
    check("mr_rxd", rxd0, 0);
    check("mr_rdy", rdy0, 1);
    check("mr_rxv", rxv0, 0);
    check("mr_abort", abt0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clk(8);
    r0 = n_rxv[0];
    q_mi.push_back(32'h3F);
    load(0, 8'h3F);
    set_cs(0, 1'b0);
    wait_clk(8);
    word(0, 32'h81, "mr_next_rd");
    wait_clk(8);
    set_cs(0, 1'b1);
    wait_clk(8);
    check("mr_next_rxv", n_rxv[0] - r0, 1);

    check("abt_total0", n_abt[0], 1);
    check("abt_others", n_abt[1] + n_abt[2] + n_abt[3], 0);
    check("rx_left", q_rx.size(), 0);
    check("mi_left", q_mi.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
